// File: rtl/enemy_fire_scheduler.sv
// enemy_fire_scheduler
//   Periodically chooses an enemy to fire. After PERIOD cycles of play it
//   picks a start column, scans columns one per cycle (wrapping) until a
//   column with a live enemy is found, and offers that column together with
//   its bottom-most live row to the enemy-bullet stage through a
//   valid/ready handshake. If every column is empty, a single-cycle
//   no_target pulse is raised instead.
//
// Parameters
//   ROWS   : enemy rows, row ROWS-1 is bottom-most
//   COLS   : enemy columns (max 16)
//   PERIOD : clock cycles between fire attempts (min 2)
//
// Ports
//   clk         : system clock, rising edge
//   reset       : synchronous, active-high reset
//   enable      : game-running qualifier; low forces the idle wait state
//   alive       : enemy alive mask, bit row*COLS+col
//   shot_ready  : bullet stage can accept a shot
//   shot_valid  : shot request pending
//   shot_col    : column of the shooting enemy
//   shot_row    : row of the shooting enemy
//   no_target   : one-cycle pulse, attempt found no live enemy
//   shots_fired : saturating count of accepted shots
//
// Build option
//   ENEMY_FIRE_RANDOM_EN : start column from a 16-bit LFSR instead of a
//                          round-robin pointer.

module enemy_fire_scheduler #(
  parameter int ROWS   = 4,
  parameter int COLS   = 10,
  parameter int PERIOD = 5000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [ROWS*COLS-1:0] alive,
  input  logic                 shot_ready,
  output logic                 shot_valid,
  output logic [3:0]           shot_col,
  output logic [1:0]           shot_row,
  output logic                 no_target,
  output logic [7:0]           shots_fired
);

  localparam int TW = $clog2(PERIOD);

  typedef enum logic [1:0] {
    S_WAIT,
    S_PICK,
    S_SEARCH,
    S_OFFER
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [3:0]      r_col;
  logic [3:0]      r_miss;
  logic            r_shot_valid;
  logic [3:0]      r_shot_col;
  logic [1:0]      r_shot_row;
  logic            r_no_target;
  logic [7:0]      r_shots_fired;

  logic [ROWS-1:0] w_colmask [COLS];
  logic            w_any;
  logic [1:0]      w_row;
  logic [3:0]      w_next_col;
  logic [3:0]      w_start;

  // Regroup the row-major alive mask into one vector per column.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign w_colmask[c][r] = alive[r*COLS + c];
    end
  end

  // Any live enemy in the column under examination, and the highest
  // (bottom-most) live row index; later rows overwrite earlier ones.
  always_comb begin
    w_any = 1'b0;
    w_row = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (w_colmask[r_col][r]) begin
        w_any = 1'b1;
        w_row = 2'(r);
      end
    end
  end

  assign w_next_col = (r_col == 4'(COLS-1)) ? '0 : r_col + 4'd1;

`ifdef ENEMY_FIRE_RANDOM_EN
  logic [15:0] r_lfsr;
  logic        w_fb;

  // Fibonacci LFSR, taps 16,14,13,11; free-running outside reset.
  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  assign w_start = (r_lfsr[3:0] >= 4'(COLS)) ? r_lfsr[3:0] - 4'(COLS)
                                              : r_lfsr[3:0];
`else
  logic [3:0] r_rr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr <= '0;
    end else if (enable && r_state == S_PICK) begin
      r_rr <= (r_rr == 4'(COLS-1)) ? '0 : r_rr + 4'd1;
    end
  end

  assign w_start = r_rr;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_WAIT;
      r_timer       <= '0;
      r_col         <= '0;
      r_miss        <= '0;
      r_shot_valid  <= 1'b0;
      r_shot_col    <= '0;
      r_shot_row    <= '0;
      r_no_target   <= 1'b0;
      r_shots_fired <= '0;
    end else begin
      r_no_target <= 1'b0;
      if (!enable) begin
        // Abandon any attempt in progress; no shot counted, no pulse.
        r_state      <= S_WAIT;
        r_timer      <= '0;
        r_shot_valid <= 1'b0;
      end else begin
        case (r_state)
          S_WAIT: begin
            if (r_timer == TW'(PERIOD-1)) begin
              r_state <= S_PICK;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          S_PICK: begin
            r_col   <= w_start;
            r_miss  <= '0;
            r_state <= S_SEARCH;
          end
          S_SEARCH: begin
            if (w_any) begin
              r_shot_col   <= r_col;
              r_shot_row   <= w_row;
              r_shot_valid <= 1'b1;
              r_state      <= S_OFFER;
            end else if (r_miss == 4'(COLS-1)) begin
              r_no_target <= 1'b1;
              r_state     <= S_WAIT;
              r_timer     <= '0;
            end else begin
              r_miss <= r_miss + 4'd1;
              r_col  <= w_next_col;
            end
          end
          S_OFFER: begin
            if (shot_ready) begin
              r_shot_valid <= 1'b0;
              if (r_shots_fired != 8'hFF) begin
                r_shots_fired <= r_shots_fired + 8'd1;
              end
              r_state <= S_WAIT;
              r_timer <= '0;
            end
          end
          default: begin
            r_state <= S_WAIT;
            r_timer <= '0;
          end
        endcase
      end
    end
  end

  assign shot_valid  = r_shot_valid;
  assign shot_col    = r_shot_col;
  assign shot_row    = r_shot_row;
  assign no_target   = r_no_target;
  assign shots_fired = r_shots_fired;

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// tb_enemy_fire_scheduler
//   Drives enemy_fire_scheduler (PERIOD=8, 4x10 field) with directed and
//   randomized stimulus and compares every cycle against a transaction-level
//   reference: each attempt is resolved as a whole (first live column from
//   the start column, bottom-most row) and its outcome is scheduled after
//   the appropriate number of cycles.

module tb_enemy_fire_scheduler;

  localparam int ROWS   = 4;
  localparam int COLS   = 10;
  localparam int PERIOD = 8;
  localparam int N      = ROWS*COLS;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [N-1:0] alive;
  logic         shot_ready;
  logic         shot_valid;
  logic [3:0]   shot_col;
  logic [1:0]   shot_row;
  logic         no_target;
  logic [7:0]   shots_fired;

  enemy_fire_scheduler #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .PERIOD (PERIOD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .alive       (alive),
    .shot_ready  (shot_ready),
    .shot_valid  (shot_valid),
    .shot_col    (shot_col),
    .shot_row    (shot_row),
    .no_target   (no_target),
    .shots_fired (shots_fired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid, m_nt, m_waiting, m_pick, m_hit;
  int          m_fired, m_col, m_row, m_rr, m_wcnt, m_cd, m_tcol, m_trow;
  logic [15:0] m_lfsr;

  always @(posedge clk) begin
    int start, k;
    if (reset) begin
      m_valid = 0; m_nt = 0; m_fired = 0; m_col = 0; m_row = 0; m_rr = 0;
      m_lfsr = 16'hACE1; m_waiting = 1; m_wcnt = 0; m_pick = 0; m_cd = 0;
    end else begin
      m_nt = 0;
      if (!enable) begin
        m_valid = 0; m_waiting = 1; m_wcnt = 0; m_pick = 0; m_cd = 0;
      end else if (m_valid) begin
        if (shot_ready) begin
          m_valid = 0;
          if (m_fired < 255) m_fired++;
          m_waiting = 1; m_wcnt = 0;
        end
      end else if (m_waiting) begin
        if (m_wcnt == PERIOD-1) begin
          m_waiting = 0; m_pick = 1;
        end else begin
          m_wcnt++;
        end
      end else if (m_pick) begin
        m_pick = 0;
`ifdef ENEMY_FIRE_RANDOM_EN
        start = int'(m_lfsr[3:0]);
        if (start >= COLS) start -= COLS;
`else
        start = m_rr;
        m_rr  = (m_rr + 1) % COLS;
`endif
        m_hit = 0; k = COLS-1;
        for (int i = 0; i < COLS; i++) begin
          if (!m_hit) begin
            int c;
            c = (start + i) % COLS;
            for (int r = 0; r < ROWS; r++)
              if (alive[r*COLS + c]) begin m_hit = 1; m_trow = r; end
            if (m_hit) begin k = i; m_tcol = c; end
          end
        end
        m_cd = k + 1;
      end else if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) begin
          if (m_hit) begin
            m_valid = 1; m_col = m_tcol; m_row = m_trow;
          end else begin
            m_nt = 1; m_waiting = 1; m_wcnt = 0;
          end
        end
      end
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("shot_valid", 32'(shot_valid), 32'(m_valid));
      check("no_target", 32'(no_target), 32'(m_nt));
      check("shots_fired", 32'(shots_fired), 32'(m_fired));
      check("exclusive", 32'(shot_valid & no_target), 32'd0);
      if (m_valid) begin
        check("shot_col", 32'(shot_col), 32'(m_col));
        check("shot_row", 32'(shot_row), 32'(m_row));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Ends in the first cycle after the reset edge (cycle 0).
  task automatic start_run(input logic en, input logic rdy, input logic [N-1:0] a);
    @(negedge clk);
    reset = 1'b1; enable = en; shot_ready = rdy; alive = a;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int n);
    bit seen;
    seen = 0; n = 0;
    while (!seen && n < max) begin
      @(negedge clk);
      n++;
      if (shot_valid) seen = 1;
    end
    if (!seen) check("wait_valid", 32'(shot_valid), 32'd1);
  endtask

  function automatic logic [N-1:0] rand_alive();
    logic [63:0] t;
    case ($urandom_range(0, 3))
      0: t = '0;
      1: t = 64'd1 << $urandom_range(0, N-1);
      2: t = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      default: t = '1;
    endcase
    return t[N-1:0];
  endfunction

  initial begin
    int n, pulses, first_pulse, valids;
    logic [N-1:0] one;
    reset = 1'b1; enable = 1'b0; shot_ready = 1'b0; alive = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(shot_valid), 32'd0);
    check("rst_col", 32'(shot_col), 32'd0);
    check("rst_row", 32'(shot_row), 32'd0);
    check("rst_nt", 32'(no_target), 32'd0);
    check("rst_fired", 32'(shots_fired), 32'd0);
    chk_on = 1'b1;

    // Full field, always ready: first shot at cycle 10, then every 11.
    start_run(1'b1, 1'b1, '1);
    wait_valid(40, n);
    check("first_latency", 32'(n), 32'd10);
    check("first_row", 32'(shot_row), 32'd3);
`ifndef ENEMY_FIRE_RANDOM_EN
    check("first_col", 32'(shot_col), 32'd0);
`endif
    wait_valid(40, n);
    check("second_latency", 32'(n), 32'd11);
`ifndef ENEMY_FIRE_RANDOM_EN
    check("second_col", 32'(shot_col), 32'd1);
`endif

    // Single enemy at bit 25 (row 2, col 5).
    one = '0; one[25] = 1'b1;
    start_run(1'b1, 1'b1, one);
    wait_valid(60, n);
`ifndef ENEMY_FIRE_RANDOM_EN
    check("bit25_latency", 32'(n), 32'd15);
`endif
    check("bit25_col", 32'(shot_col), 32'd5);
    check("bit25_row", 32'(shot_row), 32'd2);
    pulses = 0;
    repeat (40) begin @(negedge clk); if (no_target) pulses++; end
    check("bit25_no_pulse", 32'(pulses), 32'd0);

    // Empty field: pulse in the cycle after the tenth miss, then repeat.
    start_run(1'b1, 1'b1, '0);
    pulses = 0; first_pulse = -1; valids = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (no_target) begin pulses++; if (first_pulse < 0) first_pulse = c; end
      if (shot_valid) valids++;
    end
    check("empty_first_pulse", 32'(first_pulse), 32'd19);
    check("empty_pulses", 32'(pulses), 32'd3);
    check("empty_valids", 32'(valids), 32'd0);
    check("empty_fired", 32'(shots_fired), 32'd0);

    // Back-pressure: offer held 20 cycles while the field empties.
    start_run(1'b1, 1'b0, '1);
    wait_valid(40, n);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) alive = '0;
      @(negedge clk);
    end
    check("held_valid", 32'(shot_valid), 32'd1);
    check("held_row", 32'(shot_row), 32'd3);
    shot_ready = 1'b1;
    @(negedge clk);
    check("accept_valid", 32'(shot_valid), 32'd0);
    check("accept_fired", 32'(shots_fired), 32'd1);

    // Enable dropped mid-offer, then saturation of the shot counter.
    start_run(1'b1, 1'b0, '1);
    wait_valid(40, n);
    enable = 1'b0;
    @(negedge clk);
    check("drop_valid", 32'(shot_valid), 32'd0);
    check("drop_fired", 32'(shots_fired), 32'd0);
    enable = 1'b1; shot_ready = 1'b1;
    repeat (3400) @(negedge clk);
    check("saturated", 32'(shots_fired), 32'd255);

    // Randomized play, including occasional resets mid-attempt.
    start_run(1'b1, 1'b1, '1);
    repeat (3000) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 199) == 0);
      enable     = ($urandom_range(0, 99) < 95);
      shot_ready = ($urandom_range(0, 3) != 0);
      // Only change the field when no scan is pending or running.
      if ((m_valid || (m_waiting && m_wcnt < PERIOD-2)) && $urandom_range(0, 9) == 0)
        alive = rand_alive();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/enemy_fire_scheduler.md
ENEMY_FIRE_SCHEDULER -- requirements
Module: enemy_fire_scheduler

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of enemy rows (row ROWS-1 is bottom-most).
REQ-002 SHALL have parameter COLS, default 10, number of enemy columns, max 16.
REQ-003 SHALL have parameter PERIOD, default 5000000, clock cycles between fire attempts, min 2.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  game-running qualifier; high only while play is in progress.
REQ-007 SHALL have port alive  input  ROWS*COLS  enemy alive mask; bit row*COLS+col.
REQ-008 SHALL have port shot_ready  input  1  enemy-bullet stage can accept a new shot.
REQ-009 SHALL have port shot_valid  output  1  shot request pending.
REQ-010 SHALL have port shot_col  output  4  column of the shooting enemy.
REQ-011 SHALL have port shot_row  output  2  row of the shooting enemy.
REQ-012 SHALL have port no_target  output  1  one-cycle pulse: attempt found no live enemy.
REQ-013 SHALL have port shots_fired  output  8  saturating count of accepted shots.

Function
REQ-014 SHALL implement states WAIT, PICK, SEARCH, OFFER; reset and enable low force WAIT.
REQ-015 SHALL in WAIT count timer 0..PERIOD-1 while enable high; cycle with timer==PERIOD-1 moves to PICK next cycle; timer cleared on every entry to WAIT.
REQ-016 SHALL in PICK (one cycle) load search column from start-column source (see Configuration), then enter SEARCH.
REQ-017 SHALL in SEARCH examine one column per cycle: hit if any alive bit in that column.
REQ-018 SHALL on hit latch shot_col = column, shot_row = largest row index alive in that column, enter OFFER next cycle.
REQ-019 SHALL on miss advance column by 1 with wrap COLS-1 -> 0; after COLS consecutive misses pulse no_target for one cycle and return to WAIT.
REQ-020 SHALL in OFFER hold shot_valid=1 with shot_col/shot_row stable until shot_ready sampled high; then shot_valid=0 next cycle, shots_fired+1 (saturate at 255), return to WAIT.
REQ-021 SHALL ignore alive changes after the hit is latched; the offered index is not re-evaluated.
REQ-022 SHALL give latency: hit on first examined column -> shot_valid high 3 cycles after the timer==PERIOD-1 cycle; each miss adds 1 cycle.
REQ-023 SHALL on enable low in any state drop shot_valid next cycle without counting a shot; no no_target pulse.
REQ-024 SHALL never assert shot_valid and no_target in the same cycle.

Reset
REQ-025 SHALL on reset set state WAIT, timer 0, shot_valid 0, shot_col 0, shot_row 0, no_target 0, shots_fired 0, round-robin pointer 0, LFSR 16'hACE1.
REQ-026 SHALL let reset override enable and shot_ready in the same cycle, including mid-OFFER.

Configuration
REQ-027 SHALL support macro ENEMY_FIRE_RANDOM_EN.
REQ-028 SHALL when defined use a 16-bit Fibonacci LFSR (taps 16,14,13,11), advancing every non-reset cycle; start column = lfsr[3:0], minus COLS if >= COLS.
REQ-029 SHALL when undefined use a round-robin pointer as start column, incremented mod COLS at each PICK; no LFSR logic synthesized.

Verification
REQ-030 SHALL cover: PERIOD=8, no macro, reset then enable=1, alive all ones, shot_ready=1 -> shot_valid first high at cycle 10 after reset release, shot_col=0, shot_row=3; next shot shot_col=1.
REQ-031 SHALL cover: alive only bit 25 -> shot_col=5, shot_row=2, no_target never pulses.
REQ-032 SHALL cover: alive=0 -> no_target single pulse 10 cycles after PICK, shot_valid stays 0, shots_fired stays 0.
REQ-033 SHALL cover: shot_ready low 20 cycles during OFFER, alive cleared meanwhile -> shot_valid held, index unchanged; accepted on ready, shots_fired=1.
REQ-034 SHALL cover: enable dropped mid-OFFER -> shot_valid 0 next cycle, shots_fired unchanged; 300 accepted shots -> shots_fired=255.
REQ-035 SHALL cover: ENEMY_FIRE_RANDOM_EN defined, alive all ones -> shot_col sequence matches LFSR model from seed 16'hACE1, all values 0..9, shot_row=3.
